// File: rtl/serdes_pkg.sv
// Shared definitions for the framed serializer and its matching deserializer:
// FSM state encoding, default sync header and frame-length helper.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } ser_state_t;

  localparam logic [3:0] SYNC_PATTERN_DEF = 4'b1011;

  function automatic int frame_len(input int data_w, input int sync_w, input int par_en);
    return sync_w + data_w + par_en;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Parallel-load shift register feeding data bits to the framer, either MSB or
// LSB first. A load takes priority over a shift so back-to-back frames chain.
module ser_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_data <= '0;
    end else if (i_enable) begin
      if (i_load) begin
        r_data <= i_data;
      end else if (i_shift) begin
        if (MSB_FIRST) begin
          r_data <= {r_data[DATA_W-2:0], 1'b0};
        end else begin
          r_data <= {1'b0, r_data[DATA_W-1:1]};
        end
      end
    end
  end

  assign o_bit = MSB_FIRST ? r_data[DATA_W-1] : r_data[0];

endmodule

// File: rtl/ser_framer.sv
// Framing serializer: sync header, data word and optional even parity on a
// 1-bit stream. The FSM runs one cycle ahead of the registered outputs.
module ser_framer
  import serdes_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF),
  parameter bit                MSB_FIRST    = 1'b1,
  parameter bit                PARITY_EN    = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int MAX_W = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  ser_state_t       r_state;
  ser_state_t       w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_parity;
  logic             r_dout;
  logic             r_doutValid;
  logic             r_frameStart;
  logic             r_busy;
  logic             w_lastBit;
  logic             w_accept;
  logic             w_shift;
  logic             w_dataBit;
  logic             w_syncBit;
  logic             w_nextDout;

  ser_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_enable  (enable),
    .i_load    (w_accept),
    .i_shift   (w_shift),
    .i_data    (din),
    .o_bit     (w_dataBit)
  );

  always_comb begin
    w_lastBit = 1'b0;
    if (r_state == PAR) begin
      w_lastBit = 1'b1;
    end else if ((r_state == DATA) && (r_cnt == DATA_LAST) && !PARITY_EN) begin
      w_lastBit = 1'b1;
    end
  end

  assign in_ready = enable && ((r_state == IDLE) || w_lastBit);
  assign w_accept = in_valid && in_ready;
  assign w_shift  = (r_state == DATA);

  // Header is sent MSB first, so count 0 selects the top pattern bit.
  always_comb begin
    w_syncBit = 1'b0;
    for (int i = 0; i < SYNC_W; i++) begin
      if (r_cnt == CNT_W'(SYNC_W - 1 - i)) begin
        w_syncBit = SYNC_PATTERN[i];
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    if (enable) begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_stateNext = SYNC;
            w_cntNext   = '0;
          end
        end
        SYNC: begin
          if (r_cnt == SYNC_LAST) begin
            w_stateNext = DATA;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == DATA_LAST) begin
            w_cntNext = '0;
            if (PARITY_EN) begin
              w_stateNext = PAR;
            end else begin
              w_stateNext = w_accept ? SYNC : IDLE;
            end
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        PAR: begin
          w_stateNext = w_accept ? SYNC : IDLE;
          w_cntNext   = '0;
        end
        default: begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    unique case (r_state)
      SYNC:    w_nextDout = w_syncBit;
      DATA:    w_nextDout = w_dataBit;
      PAR:     w_nextDout = r_parity;
      default: w_nextDout = 1'b0;
    endcase
  end

  // Parity of a newly accepted word overwrites r_parity on the same edge the
  // previous frame's parity bit is registered out, so both frames stay correct.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_parity     <= 1'b0;
      r_dout       <= 1'b0;
      r_doutValid  <= 1'b0;
      r_frameStart <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_parity <= ^din;
      end
      if (enable) begin
        r_dout       <= w_nextDout;
        r_doutValid  <= (r_state != IDLE);
        r_frameStart <= (r_state == SYNC) && (r_cnt == '0);
        r_busy       <= (r_state != IDLE);
      end else begin
        r_doutValid  <= 1'b0;
        r_frameStart <= 1'b0;
      end
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_doutValid;
  assign frame_start = r_frameStart;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ser_framer.sv
// Self-checking bench for ser_framer: three configurations share one stimulus
// stream and are compared every cycle against a frame-queue reference model.
module tb_ser_framer;
  import serdes_pkg::*;

  localparam int N_DUT = 3;
  localparam int DW    = 8;
  localparam int SW    = 4;

  logic             clock = 1'b0;
  logic             resetN;
  logic             enable;
  logic             inValid;
  logic [DW-1:0]    din;
  logic [N_DUT-1:0] inReady;
  logic [N_DUT-1:0] dout;
  logic [N_DUT-1:0] doutValid;
  logic [N_DUT-1:0] frameStart;
  logic [N_DUT-1:0] busy;

  // dut0: MSB first + parity, dut1: LSB first + parity, dut2: LSB first, no parity
  bit cfgMsb [N_DUT] = '{1'b1, 1'b0, 1'b0};
  bit cfgPar [N_DUT] = '{1'b1, 1'b1, 1'b0};

  logic [63:0] mFrame [N_DUT];
  int          mLen   [N_DUT];
  int          mIdx   [N_DUT];
  logic        eDout  [N_DUT];
  logic        eValid [N_DUT];
  logic        eStart [N_DUT];
  logic        eBusy  [N_DUT];

  logic [63:0] cap      [N_DUT];
  int          capN     [N_DUT];
  int          readyCnt [N_DUT];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ser_framer #(.DATA_W(DW), .SYNC_W(SW), .SYNC_PATTERN(4'b1011), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut0 (
    .clock(clock), .reset_n(resetN), .enable(enable), .in_valid(inValid), .in_ready(inReady[0]),
    .din(din), .dout(dout[0]), .dout_valid(doutValid[0]), .frame_start(frameStart[0]), .busy(busy[0]));

  ser_framer #(.DATA_W(DW), .SYNC_W(SW), .SYNC_PATTERN(4'b1011), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut1 (
    .clock(clock), .reset_n(resetN), .enable(enable), .in_valid(inValid), .in_ready(inReady[1]),
    .din(din), .dout(dout[1]), .dout_valid(doutValid[1]), .frame_start(frameStart[1]), .busy(busy[1]));

  ser_framer #(.DATA_W(DW), .SYNC_W(SW), .SYNC_PATTERN(4'b1011), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut2 (
    .clock(clock), .reset_n(resetN), .enable(enable), .in_valid(inValid), .in_ready(inReady[2]),
    .din(din), .dout(dout[2]), .dout_valid(doutValid[2]), .frame_start(frameStart[2]), .busy(busy[2]));

  // Frame as a bit list: index k is the k-th bit on the wire.
  function automatic logic [63:0] buildFrame(input bit msb, input bit par, input logic [DW-1:0] data);
    logic [SW-1:0] syncPat;
    logic [63:0]   f;
    syncPat = 4'b1011;
    f = '0;
    for (int k = 0; k < SW; k++) f[k] = syncPat[SW-1-k];
    for (int j = 0; j < DW; j++) f[SW+j] = msb ? data[DW-1-j] : data[j];
    if (par) f[SW+DW] = ^data;
    return f;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < N_DUT; d++) begin
      checkVal($sformatf("dut%0d dout", d),        64'(dout[d]),       64'(eDout[d]));
      checkVal($sformatf("dut%0d dout_valid", d),  64'(doutValid[d]),  64'(eValid[d]));
      checkVal($sformatf("dut%0d frame_start", d), 64'(frameStart[d]), 64'(eStart[d]));
      checkVal($sformatf("dut%0d busy", d),        64'(busy[d]),       64'(eBusy[d]));
      checkVal($sformatf("dut%0d in_ready", d),    64'(inReady[d]),
               64'(enable && ((mLen[d] - mIdx[d]) <= 1)));
      if (doutValid[d] === 1'b1) begin
        cap[d] = {cap[d][62:0], dout[d]};
        capN[d]++;
      end
      if (inReady[d] === 1'b1) readyCnt[d]++;
    end
  endtask

  // Reference model: a pending frame is a bit list; each enabled edge issues
  // the next bit, and a word may be taken while at most one bit remains.
  task automatic modelEdge();
    for (int d = 0; d < N_DUT; d++) begin
      logic rdy;
      rdy = enable && ((mLen[d] - mIdx[d]) <= 1);
      if (!resetN) begin
        mLen[d] = 0; mIdx[d] = 0;
        eDout[d] = 1'b0; eValid[d] = 1'b0; eStart[d] = 1'b0; eBusy[d] = 1'b0;
      end else if (enable) begin
        if (mIdx[d] < mLen[d]) begin
          eDout[d]  = mFrame[d][mIdx[d]];
          eValid[d] = 1'b1;
          eStart[d] = (mIdx[d] == 0);
          eBusy[d]  = 1'b1;
          mIdx[d]++;
        end else begin
          eDout[d] = 1'b0; eValid[d] = 1'b0; eStart[d] = 1'b0; eBusy[d] = 1'b0;
        end
        if (inValid && rdy) begin
          mFrame[d] = buildFrame(cfgMsb[d], cfgPar[d], din);
          mLen[d]   = SW + DW + (cfgPar[d] ? 1 : 0);
          mIdx[d]   = 0;
        end
      end else begin
        eValid[d] = 1'b0;
        eStart[d] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic v, input logic [DW-1:0] data, input logic rstn);
    enable = en; inValid = v; din = data; resetN = rstn;
    #1;
    checkOutput();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
  endtask

  task automatic clearCap();
    for (int d = 0; d < N_DUT; d++) begin
      cap[d] = '0; capN[d] = 0; readyCnt[d] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      mFrame[d] = '0; mLen[d] = 0; mIdx[d] = 0;
      eDout[d] = 1'b0; eValid[d] = 1'b0; eStart[d] = 1'b0; eBusy[d] = 1'b0;
    end
    clearCap();
    enable = 1'b1; inValid = 1'b0; din = '0; resetN = 1'b0;
    @(posedge clock);
    @(posedge clock);
    modelEdge();
    @(negedge clock);

    // Reset state
    resetN = 1'b1;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      checkVal($sformatf("rst dut%0d dout", d),       64'(dout[d]),       64'(0));
      checkVal($sformatf("rst dut%0d valid", d),      64'(doutValid[d]),  64'(0));
      checkVal($sformatf("rst dut%0d busy", d),       64'(busy[d]),       64'(0));
      checkVal($sformatf("rst dut%0d start", d),      64'(frameStart[d]), 64'(0));
      checkVal($sformatf("rst dut%0d in_ready", d),   64'(inReady[d]),    64'(1));
    end
    @(negedge clock);

    // Single frame, A5
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1);
    idle(15);
    checkVal("a5 dut0 bits", 64'(cap[0][12:0]), 64'(13'b1011_10100101_0));
    checkVal("a5 dut0 len",  64'(capN[0]),       64'(frame_len(DW, SW, 1)));
    checkVal("a5 dut1 bits", 64'(cap[1][12:0]), 64'(13'b1011_10100101_0));
    checkVal("a5 dut2 bits", 64'(cap[2][11:0]), 64'(12'b1011_10100101));
    checkVal("a5 dut2 len",  64'(capN[2]),       64'(12));

    // Single frame, 01: exposes bit order and odd parity
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b1);
    idle(15);
    checkVal("01 dut0 bits", 64'(cap[0][12:0]), 64'(13'b1011_00000001_1));
    checkVal("01 dut1 bits", 64'(cap[1][12:0]), 64'(13'b1011_10000000_1));
    checkVal("01 dut1 len",  64'(capN[1]),       64'(13));
    checkVal("01 dut2 bits", 64'(cap[2][11:0]), 64'(12'b1011_10000000));
    checkVal("01 dut2 len",  64'(capN[2]),       64'(12));

    // Back-to-back: FF then 00 with in_valid held
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
    for (int d = 0; d < N_DUT; d++)
      checkVal($sformatf("b2b dut%0d ready count", d), 64'(readyCnt[d]), 64'(2));
    idle(15);
    checkVal("b2b dut0 bits", 64'(cap[0][25:0]), 64'({13'b1011_11111111_0, 13'b1011_00000000_0}));
    checkVal("b2b dut0 len",  64'(capN[0]),       64'(26));
    checkVal("b2b dut2 bits", 64'(cap[2][23:0]), 64'({12'b1011_11111111, 12'b1011_00000000}));

    // Enable stall at data bit 4
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'h96, 1'b1);
    idle(8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
      for (int d = 0; d < N_DUT; d++)
        checkVal($sformatf("stall dut%0d valid", d), 64'(doutValid[d]), 64'(0));
    end
    idle(16);
    checkVal("stall dut0 bits", 64'(cap[0][12:0]), 64'(13'b1011_10010110_0));
    checkVal("stall dut0 len",  64'(capN[0]),       64'(13));
    checkVal("stall dut1 bits", 64'(cap[1][12:0]), 64'(13'b1011_01101001_0));
    checkVal("stall dut2 bits", 64'(cap[2][11:0]), 64'(12'b1011_01101001));

    // Reset mid-frame at data bit 2, then reset beating a valid word
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'hE7, 1'b1);
    idle(7);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    resetN = 1'b1; inValid = 1'b0;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      checkVal($sformatf("midrst dut%0d dout", d),     64'(dout[d]),       64'(0));
      checkVal($sformatf("midrst dut%0d valid", d),    64'(doutValid[d]),  64'(0));
      checkVal($sformatf("midrst dut%0d busy", d),     64'(busy[d]),       64'(0));
      checkVal($sformatf("midrst dut%0d in_ready", d), 64'(inReady[d]),    64'(1));
    end
    @(negedge clock);
    idle(3);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
    idle(2);
    for (int d = 0; d < N_DUT; d++)
      checkVal($sformatf("rstwins dut%0d busy", d), 64'(busy[d]), 64'(0));
    clearCap();
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1);
    idle(15);
    checkVal("3c dut0 bits", 64'(cap[0][12:0]), 64'(13'b1011_00111100_0));
    checkVal("3c dut0 len",  64'(capN[0]),       64'(13));
    checkVal("3c dut1 bits", 64'(cap[1][12:0]), 64'(13'b1011_00111100_0));
    checkVal("3c dut2 bits", 64'(cap[2][11:0]), 64'(12'b1011_00111100));

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                    DW'($urandom()), ($urandom_range(0, 99) != 0));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
